// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC code sequencer: waveform modes,
// configuration register map and reset defaults.
package dac_seq_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP     = 2'd0,
        MODE_TRIANGLE = 2'd1,
        MODE_SQUARE   = 2'd2,
        MODE_HOLD     = 2'd3
    } dac_mode_e;

    localparam logic [1:0] ADDR_STEP_LO = 2'd0;
    localparam logic [1:0] ADDR_STEP_HI = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_HOLD    = 2'd3;

    localparam logic [7:0] HOLD_RST = 8'h80;
    localparam dac_mode_e  MODE_RST = MODE_RAMP;

endpackage

// File: rtl/dac_wave_shaper.sv
// Combinational waveform shaper: maps an accumulator phase, a mode and a
// static hold code onto a DAC code. Kept stateless so channels can share it.
module dac_wave_shaper
    import dac_seq_pkg::*;
#(
    parameter int CODE_W = 8
) (
    input  logic [CODE_W-1:0] phase_i,
    input  dac_mode_e         mode_i,
    input  logic [CODE_W-1:0] hold_i,
    output logic [CODE_W-1:0] code_o
);

    logic [CODE_W-1:0] triBase;

    // Triangle doubles the phase slope and mirrors the second half-period.
    always_comb begin
        triBase = {phase_i[CODE_W-2:0], 1'b0};
        code_o  = phase_i;
        case (mode_i)
            MODE_RAMP:     code_o = phase_i;
            MODE_TRIANGLE: code_o = phase_i[CODE_W-1] ? ~triBase : triBase;
            MODE_SQUARE:   code_o = phase_i[CODE_W-1] ? '1 : '0;
            MODE_HOLD:     code_o = hold_i;
            default:       code_o = phase_i;
        endcase
    end

endmodule

// File: rtl/dac_code_sequencer.sv
// Phase-accumulator waveform sequencer driving the 8-bit resistor-ladder DAC.
// Configuration lands in shadow registers and is committed at period boundaries.
module dac_code_sequencer
    import dac_seq_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    output logic [CODE_W-1:0] dac_code,
    output logic              wrap,
    output logic [1:0]        active_mode
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [15:0]       stepShadow_q, stepShadow_d;
    logic [15:0]       stepActive_q, stepActive_d;
    dac_mode_e         modeShadow_q, modeShadow_d;
    dac_mode_e         modeActive_q, modeActive_d;
    logic [CODE_W-1:0] holdShadow_q, holdShadow_d;
    logic [CODE_W-1:0] holdActive_q, holdActive_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              wrap_q, wrap_d;

    logic [ACC_W:0]    sum;
    logic              carry;
    logic              commit;
    logic [CODE_W-1:0] shaped;

    assign sum    = {1'b0, acc_q} + (ACC_W+1)'(stepActive_q);
    assign carry  = enable & sum[ACC_W];
    // An idle or stopped block has no period to protect, so it tracks shadow at once.
    assign commit = carry | ~enable | (stepActive_q == '0);

    dac_wave_shaper #(.CODE_W(CODE_W)) uShaper (
        .phase_i (acc_q[ACC_W-1 -: CODE_W]),
        .mode_i  (modeActive_q),
        .hold_i  (holdActive_q),
        .code_o  (shaped)
    );

    always_comb begin
        acc_d        = acc_q;
        code_d       = code_q;
        stepShadow_d = stepShadow_q;
        modeShadow_d = modeShadow_q;
        holdShadow_d = holdShadow_q;
        stepActive_d = stepActive_q;
        modeActive_d = modeActive_q;
        holdActive_d = holdActive_q;
        wrap_d       = carry;

        if (enable) begin
            acc_d  = sum[ACC_W-1:0];
            code_d = shaped;
        end

        // Commit reads the pre-write shadow; a coincident write waits for the next commit.
        if (commit) begin
            stepActive_d = stepShadow_q;
            modeActive_d = modeShadow_q;
            holdActive_d = holdShadow_q;
        end

        if (cfg_wr) begin
            case (cfg_addr)
                ADDR_STEP_LO: stepShadow_d[7:0]  = cfg_wdata;
                ADDR_STEP_HI: stepShadow_d[15:8] = cfg_wdata;
                ADDR_MODE:    modeShadow_d       = dac_mode_e'(cfg_wdata[1:0]);
                ADDR_HOLD:    holdShadow_d       = cfg_wdata[CODE_W-1:0];
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            stepShadow_q <= '0;
            stepActive_q <= '0;
            modeShadow_q <= MODE_RST;
            modeActive_q <= MODE_RST;
            holdShadow_q <= HOLD_RST[CODE_W-1:0];
            holdActive_q <= HOLD_RST[CODE_W-1:0];
            code_q       <= '0;
            wrap_q       <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            stepShadow_q <= stepShadow_d;
            stepActive_q <= stepActive_d;
            modeShadow_q <= modeShadow_d;
            modeActive_q <= modeActive_d;
            holdShadow_q <= holdShadow_d;
            holdActive_q <= holdActive_d;
            code_q       <= code_d;
            wrap_q       <= wrap_d;
        end
    end

    assign dac_code    = code_q;
    assign wrap        = wrap_q;
    assign active_mode = modeActive_q;

endmodule

// File: tb/tb_dac_code_sequencer.sv
// Self-checking bench for dac_code_sequencer: directed test-plan steps plus a
// randomized stretch, all compared against an arithmetic reference model.
module tb_dac_code_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic [7:0] dac_code;
    logic       wrap;
    logic [1:0] active_mode;

    int errors = 0;
    int checks = 0;
    string phaseTag = "reset";

    int mAcc, mStepSh, mStepAc, mModeSh, mModeAc, mHoldSh, mHoldAc, mCode, mWrap;

    dac_code_sequencer #(.CODE_W(8), .ACC_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .dac_code    (dac_code),
        .wrap        (wrap),
        .active_mode (active_mode)
    );

    always #5 clk = ~clk;

    // Waveform value for a 16-bit phase, straight from the mode definitions.
    function automatic int shapeRef(input int acc, input int mode, input int hold);
        int ph;
        ph = acc / 256;
        case (mode)
            0:       return ph;
            1:       return (ph < 128) ? 2 * ph : 255 - 2 * (ph - 128);
            2:       return (ph >= 128) ? 255 : 0;
            default: return hold;
        endcase
    endfunction

    task automatic modelReset();
        mAcc = 0; mStepSh = 0; mStepAc = 0;
        mModeSh = 0; mModeAc = 0;
        mHoldSh = 128; mHoldAc = 128;
        mCode = 0; mWrap = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check({phaseTag, "_code"}, {24'd0, dac_code}, mCode);
        check({phaseTag, "_wrap"}, {31'd0, wrap}, mWrap);
        check({phaseTag, "_mode"}, {30'd0, active_mode}, mModeAc);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input bit en, input bit wr, input logic [1:0] addr,
                                 input logic [7:0] data);
        int  sum;
        bit  carry;
        bit  commit;
        enable    = en;
        cfg_wr    = wr;
        cfg_addr  = addr;
        cfg_wdata = data;
        sum    = mAcc + mStepAc;
        carry  = en && (sum >= 65536);
        commit = carry || !en || (mStepAc == 0);
        if (en) begin
            mCode = shapeRef(mAcc, mModeAc, mHoldAc);
            mAcc  = sum % 65536;
        end
        mWrap = carry;
        if (commit) begin
            mStepAc = mStepSh;
            mModeAc = mModeSh;
            mHoldAc = mHoldSh;
        end
        if (wr) begin
            case (addr)
                2'd0: mStepSh = (mStepSh & 'hFF00) | int'(data);
                2'd1: mStepSh = (mStepSh & 'h00FF) | (int'(data) << 8);
                2'd2: mModeSh = int'(data) & 3;
                default: mHoldSh = int'(data);
            endcase
        end
        @(posedge clk);
        #1;
        checkOutput();
        cfg_wr = 1'b0;
    endtask

    task automatic runCycles(input int n, input bit en);
        for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, 2'd0, 8'd0);
    endtask

    initial begin
        int wrapCount;
        int cyc;

        modelReset();
        #3;
        check("rst_code", {24'd0, dac_code}, 32'h00);
        check("rst_wrap", {31'd0, wrap}, 32'h0);
        check("rst_mode", {30'd0, active_mode}, 32'h0);
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput();

        phaseTag = "ramp";
        applyStimulus(1'b1, 1'b1, 2'd0, 8'h00);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h01);
        applyStimulus(1'b1, 1'b1, 2'd2, 8'h00);
        runCycles(4, 1'b1);
        wrapCount = 0;
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
            if (wrap) wrapCount++;
        end
        check("ramp_wrap_count", wrapCount, 32'd2);

        phaseTag = "triangle";
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h04);
        applyStimulus(1'b1, 1'b1, 2'd2, 8'h01);
        runCycles(400, 1'b1);

        phaseTag = "deferred";
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h01);
        applyStimulus(1'b1, 1'b1, 2'd2, 8'h00);
        runCycles(300, 1'b1);
        runCycles(100, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'd2, 8'hFE);
        runCycles(600, 1'b1);

        phaseTag = "collision";
        cyc = 0;
        while (!(mAcc + mStepAc >= 65536) && cyc < 1000) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
            cyc++;
        end
        check("collision_reach_wrap", cyc < 1000, 32'd1);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h02);
        check("collision_wrap_edge", {31'd0, wrap}, 32'h1);
        cyc = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
            cyc++;
        end while (!wrap && cyc < 400);
        check("collision_old_period", cyc, 32'd256);
        cyc = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
            cyc++;
        end while (!wrap && cyc < 400);
        check("collision_new_period", cyc, 32'd128);

        phaseTag = "hold";
        runCycles(37, 1'b1);
        runCycles(5, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 8'h5A);
        applyStimulus(1'b0, 1'b1, 2'd2, 8'h03);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        check("hold_active_mode", {30'd0, active_mode}, 32'h3);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        check("hold_code", {24'd0, dac_code}, 32'h5A);
        runCycles(20, 1'b1);

        phaseTag = "random";
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        applyStimulus(1'b1, 1'b1, 2'd0, 8'h80);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h03);
        applyStimulus(1'b1, 1'b1, 2'd2, 8'h01);
        runCycles(300, 1'b1);

        phaseTag = "midreset";
        #2;
        reset = 1'b1;
        #1;
        check("midrst_code", {24'd0, dac_code}, 32'h00);
        check("midrst_wrap", {31'd0, wrap}, 32'h0);
        check("midrst_mode", {30'd0, active_mode}, 32'h0);
        modelReset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        runCycles(20, 1'b1);
        check("midrst_idle_code", {24'd0, dac_code}, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
